// File: rtl/spislaveio.sv
// spislaveio: CPU-mapped SPI slave (mode 0, MSB first) with a one-byte receive
// buffer, one-byte transmit buffer, status/control register and interrupt.
//
// Ports:
//   clk   - system clock, all state changes on its rising edge
//   rst   - synchronous active-high reset
//   AD    - register address ($0 status/control, $1 data, $2-$7 read as zero)
//   DI    - CPU write data
//   DO    - CPU read data, registered (one-cycle read latency)
//   rw    - 1 = read, 0 = write, qualified by cs
//   cs    - register access strobe, one access per clk cycle while high
//   irq   - interrupt request, IE && (RDY || OVR), registered
//   ssel  - SPI slave select from master, active low, asynchronous
//   sck   - SPI clock from master, idle low, asynchronous
//   mosi  - SPI data from master, asynchronous
//   miso  - SPI data to master, forced high while deselected
module spislaveio (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       ssel,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso
);

    logic [1:0] r_ssel_sync;
    logic       r_ssel_d;
    logic [2:0] r_sck_sync;
    logic [1:0] r_mosi_sync;
    logic [7:0] r_rx_data;
    logic [7:0] r_tx_data;
    logic [7:0] r_shift_tx;
    logic [7:0] r_shift_rx;
    logic [3:0] r_bit_cnt;
    logic       r_txe;
    logic       r_rdy;
    logic       r_ovr;
    logic       r_ie;
    logic [7:0] r_do;
    logic       r_irq;

    logic       w_ssel_s;
    logic       w_sel;
    logic       w_ssel_fall;
    logic       w_ssel_rise;
    logic       w_sck_rise;
    logic       w_sck_fall;
    logic       w_mosi_s;
    logic       w_rise_act;
    logic       w_fall_act;
    logic       w_reload;
    logic       w_done;
    logic [7:0] w_byte;
    logic       w_rd;
    logic       w_rd1;
    logic       w_wr0;
    logic       w_wr1;
    logic [7:0] w_rd_data;

    assign w_ssel_s    = r_ssel_sync[1];
    assign w_sel       = ~w_ssel_s;
    assign w_ssel_fall = ~w_ssel_s & r_ssel_d;
    assign w_ssel_rise = w_ssel_s & ~r_ssel_d;
    // The third sck flop gives the previous synchronized level, so an edge
    // takes effect three clk cycles after the pin changes.
    assign w_sck_rise  = r_sck_sync[1] & ~r_sck_sync[2];
    assign w_sck_fall  = ~r_sck_sync[1] & r_sck_sync[2];
    assign w_mosi_s    = r_mosi_sync[1];

    // A select edge owns the cycle; sck edges only count while selected.
    assign w_rise_act  = w_sck_rise & w_sel & ~w_ssel_fall;
    assign w_fall_act  = w_sck_fall & w_sel & ~w_ssel_fall;
    assign w_reload    = w_ssel_fall | (w_fall_act & (r_bit_cnt == 4'd8));
    assign w_done      = w_rise_act & (r_bit_cnt == 4'd7);
    assign w_byte      = {r_shift_rx[6:0], w_mosi_s};

    assign w_rd        = cs & rw;
    assign w_rd1       = w_rd & (AD == 3'd1);
    assign w_wr0       = cs & ~rw & (AD == 3'd0);
    assign w_wr1       = cs & ~rw & (AD == 3'd1);

    always_comb begin
        w_rd_data = (AD == 3'd0) ? {r_rdy, r_txe, r_ovr, w_sel, 3'b000, r_ie} :
                    (AD == 3'd1) ? r_rx_data : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ssel_sync <= 2'b11;
            r_ssel_d    <= 1'b1;
            r_sck_sync  <= 3'b000;
            r_mosi_sync <= 2'b11;
            r_rx_data   <= 8'hFF;
            r_tx_data   <= 8'hFF;
            r_shift_tx  <= 8'hFF;
            r_shift_rx  <= 8'h00;
            r_bit_cnt   <= 4'd0;
            r_txe       <= 1'b1;
            r_rdy       <= 1'b0;
            r_ovr       <= 1'b0;
            r_ie        <= 1'b0;
            r_do        <= 8'h00;
            r_irq       <= 1'b0;
        end else begin
            r_ssel_sync <= {r_ssel_sync[0], ssel};
            r_ssel_d    <= w_ssel_s;
            r_sck_sync  <= {r_sck_sync[1:0], sck};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
            if (w_rd)
                r_do <= w_rd_data;
            r_irq <= r_ie & (r_rdy | r_ovr);
            if (w_wr0)
                r_ie <= DI[0];
            if (w_wr1)
                r_tx_data <= DI;
            // Reload consumes the pre-write buffer; a same-cycle CPU write
            // still leaves its new byte pending (TXE = 0).
            r_txe <= w_wr1 ? 1'b0 : (w_reload ? 1'b1 : r_txe);
            if (w_reload)
                r_shift_tx <= r_txe ? 8'hFF : r_tx_data;
            else if (w_fall_act)
                r_shift_tx <= {r_shift_tx[6:0], 1'b1};
            if (w_rise_act) begin
                r_shift_rx <= w_byte;
                r_bit_cnt  <= r_bit_cnt + 4'd1;
            end else if (w_ssel_fall | w_ssel_rise | w_reload)
                r_bit_cnt <= 4'd0;
            if (w_done)
                r_rx_data <= w_byte;
            // Completion beats a same-cycle $1 read; a read that empties the
            // buffer in that cycle is not an overrun.
            r_rdy <= w_done | (r_rdy & ~w_rd1);
            r_ovr <= (w_done & r_rdy & ~w_rd1) | (r_ovr & ~(w_wr0 & DI[5]));
        end
    end

    assign DO   = r_do;
    assign irq  = r_irq;
    assign miso = w_sel ? r_shift_tx[7] : 1'b1;

endmodule

// File: tb/tb_spislaveio.sv
// tb_spislaveio: directed self-checking bench for spislaveio.
module tb_spislaveio;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;
    logic       irq;
    logic       ssel;
    logic       sck;
    logic       mosi;
    logic       miso;

    int errs = 0;
    int checks = 0;

    spislaveio dut (
        .clk (clk),
        .rst (rst),
        .AD  (AD),
        .DI  (DI),
        .DO  (DO),
        .rw  (rw),
        .cs  (cs),
        .irq (irq),
        .ssel(ssel),
        .sck (sck),
        .mosi(mosi),
        .miso(miso)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        AD = a;
        rw = 1'b1;
        cs = 1'b1;
        tick;
        cs = 1'b0;
        check(tag, DO, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        AD = a;
        DI = d;
        rw = 1'b0;
        cs = 1'b1;
        tick;
        cs = 1'b0;
    endtask

    task automatic ssel_set(input logic v);
        ssel = v;
        repeat (4) tick;
    endtask

    // mode 0: plain byte, 1: $1 read lands on the edge where the last rise
    // acts, 2: check irq around RDY being set on the last rise.
    task automatic spi_byte(input logic [7:0] tx, input int nbits, input int mode,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (4) tick;
            rx[7-i] = miso;
            sck = 1'b1;
            if (mode == 1 && i == 7) begin
                tick;
                tick;
                AD = 3'd1;
                rw = 1'b1;
                cs = 1'b1;
                tick;
                cs = 1'b0;
                tick;
            end else if (mode == 2 && i == 7) begin
                tick;
                tick;
                tick;
                check("irq_same_cycle_as_rdy", {7'b0, irq}, 8'h00);
                tick;
                check("irq_one_after_rdy", {7'b0, irq}, 8'h01);
            end else
                repeat (4) tick;
            sck = 1'b0;
        end
        repeat (4) tick;
    endtask

    logic [7:0] rx;

    initial begin
        rst = 1'b1; ssel = 1'b1; sck = 1'b0; mosi = 1'b1;
        cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'h00;
        repeat (3) tick;
        check("rst_do", DO, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);
        check("rst_miso", {7'b0, miso}, 8'h01);
        rst = 1'b0;
        tick;
        rd_chk("rst_stat", 3'd0, 8'h40);
        rd_chk("rst_rxdata", 3'd1, 8'hFF);

        wr(3'd5, 8'h77);
        rd_chk("rd_addr5", 3'd5, 8'h00);
        wr(3'd1, 8'hA5);
        rd_chk("stat_txe_clr", 3'd0, 8'h00);
        ssel_set(1'b0);
        spi_byte(8'h3C, 8, 0, rx);
        check("miso_a5", rx, 8'hA5);
        rd_chk("stat_sel_rdy", 3'd0, 8'hD0);
        rd_chk("rx_3c", 3'd1, 8'h3C);
        rd_chk("stat_after_rd", 3'd0, 8'h50);
        ssel_set(1'b1);
        check("miso_desel", {7'b0, miso}, 8'h01);

        ssel_set(1'b0);
        spi_byte(8'h01, 8, 0, rx);
        check("miso_idle1", rx, 8'hFF);
        spi_byte(8'h02, 8, 0, rx);
        check("miso_idle2", rx, 8'hFF);
        ssel_set(1'b1);
        rd_chk("stat_ovr", 3'd0, 8'hE0);
        rd_chk("rx_02", 3'd1, 8'h02);
        wr(3'd0, 8'h20);
        rd_chk("stat_ovr_clr", 3'd0, 8'h40);

        wr(3'd0, 8'h01);
        check("irq_idle", {7'b0, irq}, 8'h00);
        ssel_set(1'b0);
        spi_byte(8'h55, 8, 2, rx);
        rd_chk("rx_55", 3'd1, 8'h55);
        check("irq_at_read", {7'b0, irq}, 8'h01);
        tick;
        check("irq_after_read", {7'b0, irq}, 8'h00);
        ssel_set(1'b1);

        ssel_set(1'b0);
        spi_byte(8'hAA, 5, 0, rx);
        ssel_set(1'b1);
        rd_chk("stat_partial", 3'd0, 8'h41);
        ssel_set(1'b0);
        spi_byte(8'h81, 8, 0, rx);
        ssel_set(1'b1);
        rd_chk("stat_81", 3'd0, 8'hC1);
        rd_chk("rx_81", 3'd1, 8'h81);

        ssel_set(1'b0);
        spi_byte(8'h3C, 8, 0, rx);
        spi_byte(8'hC3, 8, 1, rx);
        check("collide_do", DO, 8'h3C);
        rd_chk("collide_stat", 3'd0, 8'hD1);
        rd_chk("collide_rx", 3'd1, 8'hC3);
        ssel_set(1'b1);

        wr(3'd1, 8'h5A);
        ssel_set(1'b0);
        spi_byte(8'hF0, 4, 0, rx);
        rst = 1'b1;
        ssel = 1'b1;
        repeat (3) tick;
        check("mid_rst_do", DO, 8'h00);
        check("mid_rst_irq", {7'b0, irq}, 8'h00);
        check("mid_rst_miso", {7'b0, miso}, 8'h01);
        rst = 1'b0;
        tick;
        rd_chk("mid_rst_stat", 3'd0, 8'h40);
        rd_chk("mid_rst_rx", 3'd1, 8'hFF);
        ssel_set(1'b0);
        spi_byte(8'h96, 8, 0, rx);
        check("post_rst_miso", rx, 8'hFF);
        ssel_set(1'b1);
        rd_chk("post_rst_rx", 3'd1, 8'h96);
        wr(3'd1, 8'h6B);
        ssel_set(1'b0);
        spi_byte(8'h24, 8, 0, rx);
        check("post_rst_miso_6b", rx, 8'h6B);
        ssel_set(1'b1);
        rd_chk("post_rst_rx_24", 3'd1, 8'h24);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/spislaveio.md
SPISLAVEIO -- requirements
Module: spislaveio

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. clk is the only clock. rst is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 AD  input  3  register address.
REQ-005 DI  input  8  CPU write data.
REQ-006 DO  output  8  CPU read data, registered.
REQ-007 rw  input  1  1 = read, 0 = write; qualified by cs.
REQ-008 cs  input  1  register access strobe, one access per clk cycle while high.
REQ-009 irq  output  1  interrupt request, active high.
REQ-010 ssel  input  1  SPI slave select from external master, active low, asynchronous.
REQ-011 sck  input  1  SPI clock from master, mode 0 (idle low), asynchronous.
REQ-012 mosi  input  1  SPI data from master, asynchronous.
REQ-013 miso  output  1  SPI data to master.

Function
REQ-014 Register $0 read SHALL return {RDY, TXE, OVR, SEL, 3'b000, IE}; SEL = synchronized ssel is low.
REQ-015 Register $0 write SHALL set IE <= DI[0]; DI[5]=1 SHALL clear OVR; other bits ignored.
REQ-016 Register $1 read SHALL return rx_data and clear RDY; $1 write SHALL load tx_data <= DI and clear TXE.
REQ-017 Reads of addresses $2-$7 SHALL return 8'h00; writes SHALL be ignored.
REQ-018 DO SHALL update on the clk edge in which cs && rw, giving one-cycle read latency; DO holds otherwise.
REQ-019 ssel, sck and mosi SHALL each pass through a 2-flop synchronizer; sck edges SHALL be detected from a third flop, so an edge acts 3 clk cycles after the pin changes.
REQ-020 Correct operation SHALL be required only when sck high and low phases each last >= 4 clk cycles; faster sck is out of scope.
REQ-021 Synchronized ssel falling SHALL: bit_cnt <= 0; shift_tx <= tx_data and TXE <= 1 if TXE == 0, else shift_tx <= 8'hFF.
REQ-022 Synchronized sck rising while selected SHALL: shift_rx <= {shift_rx[6:0], mosi_s}; bit_cnt <= bit_cnt + 1.
REQ-023 On the 8th rising edge, the block SHALL: rx_data <= completed byte and RDY <= 1; OVR <= 1 if RDY was already 1 and not cleared in the same cycle.
REQ-024 Synchronized sck falling while selected SHALL reload shift_tx as in REQ-021 and set bit_cnt <= 0 if bit_cnt == 8; otherwise it SHALL shift shift_tx <= {shift_tx[6:0], 1'b1}.
REQ-025 MSB first: miso SHALL equal shift_tx[7] while selected and 1'b1 while deselected.
REQ-026 Synchronized ssel rising SHALL discard a partial byte (bit_cnt <= 0) without setting RDY; sck edges while deselected SHALL be ignored.
REQ-027 irq SHALL equal IE && (RDY || OVR), registered.
REQ-028 Simultaneous byte completion and $1 read: DO SHALL get the old rx_data and RDY SHALL remain 1 (set wins).
REQ-029 Simultaneous $1 write and tx reload: the reload SHALL use pre-write tx_data/TXE; the new byte SHALL be kept with TXE = 0 (write wins).
REQ-030 Simultaneous OVR set and OVR-clear write: OVR SHALL end at 1.

Reset
REQ-031 When rst is high, the block SHALL set: DO = 8'h00, irq = 0, miso = 1, rx_data = 8'hFF, tx_data = 8'hFF, shift_tx = 8'hFF, shift_rx = 8'h00, TXE = 1, RDY = 0, OVR = 0, IE = 0, bit_cnt = 0, and all synchronizers to ssel = 1, sck = 0, mosi = 1.
REQ-032 If rst asserts mid-transfer, the block SHALL abort the byte; after reset it SHALL wait for the next ssel falling edge before shifting.

Verification
REQ-033 The bench SHALL cover: write $1 = 8'hA5, then master sends 8'h3C at sck = clk/8 -> miso bits 1,0,1,0,0,1,0,1; $0 reads 8'hD0 while selected (RDY, TXE, SEL); $1 read = 8'h3C, then $0 = 8'h50.
REQ-034 The bench SHALL cover: no $1 write, master sends two bytes 8'h01, 8'h02 without reading -> miso all ones; OVR = 1, rx_data = 8'h02; write $0 = 8'h20 clears OVR.
REQ-035 The bench SHALL cover: IE = 1, byte received -> irq high 1 cycle after RDY; $1 read -> irq low next cycle.
REQ-036 The bench SHALL cover: ssel deasserted after 5 sck pulses -> RDY stays 0; next full byte 8'h81 is received correctly.
REQ-037 The bench SHALL cover: $1 read in the same cycle as the 8th rising edge -> DO = previous byte, RDY = 1, OVR unchanged.
REQ-038 The bench SHALL cover: rst pulsed after 4 bits of a transfer -> all reset values per REQ-031; the following transfer completes normally.
